// File: rtl/synapse316_uart_tx_arbiter.sv
// Round-robin arbiter that lends the single UART TX FIFO write port to one requester
// for a whole message, a burst limit or an idle timeout, whichever comes first.
module synapse316_uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = 64,
   parameter int IDLE_TIMEOUT = 255
) (
   input  logic                 sysclk,
   input  logic                 sysreset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           fifo_data,
   output logic                 fifo_load,
   input  logic                 fifo_full,
   output logic [2:0]           grant_id,
   output logic                 busy,
   output logic                 timeout_pulse
);

   typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, LOCK = 2'd2} state_t;

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
   localparam logic [7:0] IDLE_LAST  = 8'(IDLE_TIMEOUT - 1);
   localparam logic [2:0] PTR_LAST   = 3'(NUM_REQ - 1);

   state_t     state_r, state_s;
   logic [2:0] rr_ptr_r, grant_r, winner_s, scan_s;
   logic [7:0] burst_cnt_r, idle_cnt_r, g_data_s;
   logic       found_s, g_valid_s, g_last_s, lock_s, xfer_s;
   logic       done_msg_s, done_burst_s, tmo_s, release_s;

   function automatic logic [2:0] wrap_inc(input logic [2:0] v);
      return (v == PTR_LAST) ? 3'd0 : v + 3'd1;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Round-robin search starting at rr_ptr; explicit wrap keeps non-power-of-2 counts exact
   always_comb begin
      found_s  = 1'b0;
      winner_s = 3'd0;
      scan_s   = rr_ptr_r;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            winner_s = (!found_s && scan_s == 3'(j) && req_valid[j]) ? scan_s : winner_s;
            found_s  = found_s | (scan_s == 3'(j) && req_valid[j]);
         end
         scan_s = wrap_inc(scan_s);
      end
   end

   // Select the granted requester's handshake signals and byte
   always_comb begin
      g_valid_s = 1'b0;
      g_last_s  = 1'b0;
      g_data_s  = 8'd0;
      for (int j = 0; j < NUM_REQ; j++) begin
         g_valid_s = g_valid_s | ((grant_r == 3'(j)) & req_valid[j]);
         g_last_s  = g_last_s  | ((grant_r == 3'(j)) & req_last[j]);
         g_data_s  = g_data_s  | ({8{grant_r == 3'(j)}} & req_data[8*j +: 8]);
      end
   end

   // Same-cycle pass-through; sysreset masks the strobe so a byte offered under reset is never written
   always_comb begin
      lock_s       = (state_r == LOCK) && !sysreset;
      xfer_s       = lock_s && g_valid_s && !fifo_full;
      done_msg_s   = xfer_s && g_last_s;
      done_burst_s = xfer_s && (burst_cnt_r == BURST_LAST);
      tmo_s        = lock_s && !g_valid_s && (idle_cnt_r == IDLE_LAST);
      release_s    = done_msg_s || done_burst_s || tmo_s;
      for (int j = 0; j < NUM_REQ; j++) begin
         req_ready[j] = lock_s && !fifo_full && (grant_r == 3'(j));
      end
      fifo_load     = xfer_s;
      fifo_data     = xfer_s ? g_data_s : 8'd0;
      timeout_pulse = tmo_s;
      grant_id      = grant_r;
      busy          = (state_r == LOCK);
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = (|req_valid) ? ARB : IDLE;
         ARB:     state_s = found_s ? LOCK : IDLE;
         LOCK:    state_s = release_s ? IDLE : LOCK;
         default: state_s = IDLE;
      endcase
   end

   // State, pointer, grant and saturating counters
   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         state_r     <= IDLE;
         rr_ptr_r    <= 3'd0;
         grant_r     <= 3'd0;
         burst_cnt_r <= 8'd0;
         idle_cnt_r  <= 8'd0;
      end else begin
         state_r <= state_s;
         case (state_r)
            ARB: begin
               grant_r     <= found_s ? winner_s : 3'd0;
               burst_cnt_r <= 8'd0;
               idle_cnt_r  <= 8'd0;
            end
            LOCK: begin
               if (xfer_s) begin
                  burst_cnt_r <= sat_inc(burst_cnt_r);
                  idle_cnt_r  <= 8'd0;
               end else if (!g_valid_s) begin
                  idle_cnt_r  <= sat_inc(idle_cnt_r);
               end
               if (release_s) begin
                  rr_ptr_r <= wrap_inc(grant_r);
                  grant_r  <= 3'd0;
               end
            end
            default: begin
               grant_r <= 3'd0;
            end
         endcase
      end
   end

endmodule
